frame_buf_ctrl: RTL and testbench

FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

---
 rtl/frame_buf_ctrl.sv | 161 ++++++++++++++++
 tb/tb_frame_buf_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - double-buffered frame capture writer with a single-lock display reader
module frame_buf_ctrl #(
  parameter int COL = 640,
  parameter int ROW = 480,
  parameter int AW  = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cap_vld,
  input  logic          cap_sop,
  input  logic          cap_eop,
  output logic          en_capture,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  input  logic          rd_req,
  input  logic          rd_done,
  output logic          rd_ack,
  output logic          rd_none,
  output logic          rd_bank,
  output logic          frame_done,
  output logic          err_sync,
  output logic          err_drop
);

  localparam int            NPIX     = COL * ROW;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW-1:0] BANK_SZ  = AW'(NPIX);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, WRITE, DRAIN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] pix;
  logic          wbank, last, last_vld, lock_vld, lock_bank, drain_pend;
  logic [1:0]    full;
  logic          fd_q, es_q, ed_q, ack_q, none_q, bank_q;

  logic          eb, wb, beat, enter_write, commit, sync_err, drop, drain_go;
  logic [AW-1:0] bidx;
  logic [1:0]    full_n;
  logic          last_n, lvld_n;
  logic          grant, lk_vld_n, lk_bank_n, other_locked;

  // A new frame never starts in the bank the display currently holds.
  assign eb       = (lock_vld && lock_bank == wbank) ? ~wbank : wbank;
  assign drain_go = drain_pend | ((state == WRITE) & stop);

  always_comb begin
    state_n     = state;
    beat        = 1'b0;
    enter_write = 1'b0;
    bidx        = pix;
    wb          = wbank;
    commit      = 1'b0;
    sync_err    = 1'b0;
    drop        = 1'b0;
    full_n      = full;
    last_n      = last;
    lvld_n      = last_vld;
    case (state)
      IDLE: if (start) state_n = WAIT_SOP;
      WAIT_SOP: begin
        if (stop) begin
          state_n = IDLE;
        end else if (cap_vld && cap_sop) begin
          beat        = 1'b1;
          enter_write = 1'b1;
          bidx        = '0;
          wb          = eb;
          state_n     = WRITE;
        end
      end
      WRITE: begin
        if (cap_vld) begin
          beat = 1'b1;
          if (cap_sop) begin
            bidx     = '0;
            sync_err = 1'b1;
          end
        end
      end
      DRAIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (beat) begin
      if (enter_write) begin
        drop       = full[wb] && last_vld && (last == wb);
        full_n[wb] = 1'b0;
        if (drop) lvld_n = 1'b0;
      end
      // A full frame without eop is an overrun; restart rather than spill into the other bank.
      if (cap_eop || bidx == LAST_PIX) begin
        if (cap_eop && bidx == LAST_PIX) commit = 1'b1;
        else sync_err = 1'b1;
        state_n = drain_go ? DRAIN : WAIT_SOP;
      end
      if (commit) begin
        full_n[wb] = 1'b1;
        last_n     = wb;
        lvld_n     = 1'b1;
      end
    end
  end

  // Reader sees the writer's post-cycle view so a same-cycle commit is grantable.
  assign grant        = lvld_n && full_n[last_n];
  assign lk_vld_n     = rd_req ? grant : (rd_done ? 1'b0 : lock_vld);
  assign lk_bank_n    = (rd_req && grant) ? last_n : lock_bank;
  assign other_locked = lk_vld_n && (lk_bank_n != wb);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      pix        <= '0;
      wbank      <= 1'b0;
      full       <= 2'b00;
      last       <= 1'b0;
      last_vld   <= 1'b0;
      lock_vld   <= 1'b0;
      lock_bank  <= 1'b0;
      drain_pend <= 1'b0;
      fd_q       <= 1'b0;
      es_q       <= 1'b0;
      ed_q       <= 1'b0;
      ack_q      <= 1'b0;
      none_q     <= 1'b0;
      bank_q     <= 1'b0;
    end else begin
      state    <= state_n;
      full     <= full_n;
      last     <= last_n;
      last_vld <= lvld_n;
      if (beat) pix <= (state_n == WRITE) ? bidx + AW'(1) : '0;
      if (commit) wbank <= other_locked ? wb : ~wb;
      else if (enter_write) wbank <= eb;
      if (state == DRAIN) drain_pend <= 1'b0;
      else if (state == WRITE && stop) drain_pend <= 1'b1;
      fd_q      <= commit;
      es_q      <= sync_err;
      ed_q      <= drop;
      ack_q     <= rd_req;
      none_q    <= rd_req && !grant;
      if (rd_req && grant) bank_q <= last_n;
      lock_vld  <= lk_vld_n;
      lock_bank <= lk_bank_n;
    end
  end

  assign en_capture = ~rst_n & ((state == WAIT_SOP) | (state == WRITE));
  assign wr_en      = ~rst_n & beat;
  assign wr_addr    = wr_en ? ((wb ? BANK_SZ : '0) + bidx) : '0;
  assign frame_done = ~rst_n & fd_q;
  assign err_sync   = ~rst_n & es_q;
  assign err_drop   = ~rst_n & ed_q;
  assign rd_ack     = ~rst_n & ack_q;
  assign rd_none    = ~rst_n & none_q;
  assign rd_bank    = ~rst_n & bank_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// tb/tb_frame_buf_ctrl.sv - directed bench for frame_buf_ctrl with COL=4, ROW=2
module tb_frame_buf_ctrl;

  localparam int COL = 4;
  localparam int ROW = 2;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, cap_vld, cap_sop, cap_eop, rd_req, rd_done;
  logic          en_capture, wr_en, rd_ack, rd_none, rd_bank, frame_done, err_sync, err_drop;
  logic [AW-1:0] wr_addr;

  int passed = 0;
  int total  = 0;

  frame_buf_ctrl #(.COL(COL), .ROW(ROW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cap_vld(cap_vld), .cap_sop(cap_sop), .cap_eop(cap_eop),
    .en_capture(en_capture), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_req(rd_req), .rd_done(rd_done), .rd_ack(rd_ack), .rd_none(rd_none),
    .rd_bank(rd_bank), .frame_done(frame_done), .err_sync(err_sync), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({en_capture, wr_en, wr_addr, rd_ack, rd_none, rd_bank,
                  frame_done, err_sync, err_drop}), 32'd0);
  endtask

  task automatic clear_inputs();
    start = 0; stop = 0; cap_vld = 0; cap_sop = 0; cap_eop = 0; rd_req = 0; rd_done = 0;
  endtask

  task automatic pulse(input logic st, input logic sp, input logic rq, input logic dn);
    @(negedge clk);
    start = st; stop = sp; rd_req = rq; rd_done = dn;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic beat(input logic s, input logic e, input logic sp, input logic rq,
                      input logic dn, input logic exp_we, input int exp_addr, input string tag);
    @(negedge clk);
    cap_vld = 1; cap_sop = s; cap_eop = e; stop = sp; rd_req = rq; rd_done = dn;
    #1;
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(exp_we));
    chk({tag, ".wr_addr"}, 32'(wr_addr), exp_addr);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic frame(input int base, input logic exp_drop, input logic rq_last,
                       input logic dn_last, input int stop_at, input string tag);
    for (int i = 0; i < COL * ROW; i++) begin
      beat(i == 0, i == COL * ROW - 1, i == stop_at, rq_last && i == COL * ROW - 1,
           dn_last && i == COL * ROW - 1, 1'b1, base + i, $sformatf("%s.b%0d", tag, i));
      if (i == 0) chk({tag, ".err_drop"}, 32'(err_drop), 32'(exp_drop));
    end
    chk({tag, ".frame_done"}, 32'(frame_done), 32'd1);
    chk({tag, ".err_sync"}, 32'(err_sync), 32'd0);
  endtask

  initial begin
    rst_n = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_zero("in_reset");
    rst_n = 0;
    @(posedge clk); #1;
    chk_zero("first_after_reset");

    pulse(0, 0, 1, 0);
    chk("empty.rd_ack", 32'(rd_ack), 32'd1);
    chk("empty.rd_none", 32'(rd_none), 32'd1);
    pulse(0, 0, 0, 0);
    chk("empty.ack_pulse", 32'(rd_ack), 32'd0);

    pulse(1, 0, 0, 0);
    chk("start.en", 32'(en_capture), 32'd1);
    pulse(0, 1, 0, 0);
    chk("stop_wait.en", 32'(en_capture), 32'd0);
    pulse(1, 0, 0, 0);
    chk("restart.en", 32'(en_capture), 32'd1);
    beat(0, 0, 0, 0, 0, 1'b0, 0, "no_sop");

    frame(0, 0, 0, 0, -1, "f0");
    pulse(0, 0, 0, 0);
    chk("f0.done_pulse", 32'(frame_done), 32'd0);

    pulse(0, 0, 1, 0);
    chk("rd0.ack", 32'(rd_ack), 32'd1);
    chk("rd0.none", 32'(rd_none), 32'd0);
    chk("rd0.bank", 32'(rd_bank), 32'd0);

    frame(8, 0, 0, 0, -1, "f1");
    frame(8, 1, 0, 0, -1, "f2");
    frame(8, 1, 1, 0, -1, "f3");
    chk("rd1.ack", 32'(rd_ack), 32'd1);
    chk("rd1.none", 32'(rd_none), 32'd0);
    chk("rd1.bank", 32'(rd_bank), 32'd1);
    frame(0, 0, 0, 1, -1, "f4");

    for (int i = 0; i < 6; i++)
      beat(i == 0, i == 5, 0, 0, 0, 1'b1, 8 + i, $sformatf("short.b%0d", i));
    chk("short.err_sync", 32'(err_sync), 32'd1);
    chk("short.frame_done", 32'(frame_done), 32'd0);

    frame(8, 0, 0, 0, 2, "f5");
    chk("drain.en", 32'(en_capture), 32'd0);
    pulse(1, 0, 0, 0);
    chk("drain.start_ignored", 32'(en_capture), 32'd0);
    beat(1, 0, 0, 0, 0, 1'b0, 0, "idle_beat");
    pulse(1, 0, 0, 0);
    chk("idle.start", 32'(en_capture), 32'd1);

    beat(1, 0, 0, 0, 0, 1'b1, 0, "mid.b0");
    beat(0, 0, 0, 0, 0, 1'b1, 1, "mid.b1");
    @(negedge clk);
    rst_n = 1; cap_vld = 1;
    #1;
    chk_zero("mid_reset.during");
    @(posedge clk); #1;
    chk_zero("mid_reset.next");
    @(negedge clk);
    rst_n = 0; cap_vld = 0;
    @(posedge clk); #1;
    chk_zero("mid_reset.after");

    pulse(1, 0, 0, 0);
    frame(0, 0, 0, 0, -1, "f6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
